// File: rtl/cpu1_debug_pkg.sv
// rtl/cpu1_debug_pkg.sv - shared jdo fields, FSM states and status bits for the CPU1 debug monitor
package cpu1_debug_pkg;

    localparam int JDO_W           = 38;
    localparam int JDO_DATA_LSB    = 3;
    localparam int JDO_DATA_MSB    = 34;
    localparam int JDO_ADDR_LSB    = 3;
    localparam int JDO_CLR_ERR_BIT = 11;
    localparam int JDO_RD_BIT      = 12;
    localparam int JDO_SET_GO_BIT  = 13;

    localparam int STAT_READY_BIT  = 0;
    localparam int STAT_ERROR_BIT  = 1;
    localparam int STAT_GO_BIT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_J_RD,
        ST_J_RD_CAP,
        ST_J_WR
    } state_e;

    typedef enum logic {
        JOP_RD,
        JOP_WR
    } jop_e;

    function automatic logic [31:0] status_word(input logic go, input logic error, input logic ready);
        logic [31:0] w;
        w                 = '0;
        w[STAT_GO_BIT]    = go;
        w[STAT_ERROR_BIT] = error;
        w[STAT_READY_BIT] = ready;
        return w;
    endfunction

endpackage

// File: rtl/cpu1_debug_monitor_ram.sv
// rtl/cpu1_debug_monitor_ram.sv - single-port monitor RAM, byte-enable write, registered read
module cpu1_debug_monitor_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       q
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/cpu1_debug_monitor_mem.sv
// rtl/cpu1_debug_monitor_mem.sv - monitor RAM and status register shared by JTAG debug slave and CPU port
module cpu1_debug_monitor_mem
    import cpu1_debug_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W:0]   address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d, error_q, error_d, go_q, go_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              rd_status_q, rd_status_d;
    logic [31:0]       status_rd_q, status_rd_d;
    logic              pend_valid_q, pend_valid_d;
    jop_e              pend_op_q, pend_op_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]       pend_data_q, pend_data_d;

    logic              cpu_req, cpu_start, cpu_is_status, st_wr;
    logic              jtag_strobe, jtag_clr_err, jtag_set_go, jtag_drop;
    logic [ADDR_W-1:0] jdo_addr, ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata, ram_q;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

    assign cpu_req       = read | write;
    assign cpu_start     = (state_q == ST_IDLE) & cpu_req;
    assign cpu_is_status = address[ADDR_W];
    assign st_wr         = cpu_start & write & debugaccess & cpu_is_status;
    assign jtag_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign jdo_addr      = jdo[JDO_ADDR_LSB +: ADDR_W];

    // JTAG ops address the RAM from the pending slot; otherwise the CPU port drives it
    assign ram_addr  = (state_q == ST_J_RD || state_q == ST_J_WR) ? pend_addr_q : address[ADDR_W-1:0];
    assign ram_we    = (state_q == ST_J_WR) | (cpu_start & write & debugaccess & ~cpu_is_status);
    assign ram_be    = (state_q == ST_J_WR) ? 4'hF : byteenable;
    assign ram_wdata = (state_q == ST_J_WR) ? pend_data_q : writedata;

    cpu1_debug_monitor_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    always_comb begin
        state_d      = state_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        ready_d      = ready_q;
        error_d      = error_q;
        go_d         = go_q;
        cpu_ack_d    = 1'b0;
        rd_status_d  = rd_status_q;
        status_rd_d  = status_rd_q;
        pend_valid_d = pend_valid_q;
        pend_op_d    = pend_op_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        jtag_clr_err = 1'b0;
        jtag_set_go  = 1'b0;
        jtag_drop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d     = ST_CPU_ACC;
                    cpu_ack_d   = 1'b1;
                    rd_status_d = cpu_is_status;
                    status_rd_d = status_word(go_q, error_q, ready_q);
                end else if (pend_valid_q) begin
                    state_d = (pend_op_q == JOP_RD) ? ST_J_RD : ST_J_WR;
                end
            end
            ST_CPU_ACC: state_d = ST_IDLE;
            ST_J_RD:    state_d = ST_J_RD_CAP;
            ST_J_RD_CAP: begin
                mon_d_d      = ram_q;
                mon_a_d      = mon_a_q + ADDR_W'(1);
                pend_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_J_WR: begin
                mon_a_d      = mon_a_q + ADDR_W'(1);
                pend_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // pending slot only frees in J_RD_CAP/J_WR, so acceptance never collides with completion
        if (jtag_strobe) begin
            if (pend_valid_q) begin
                jtag_drop = 1'b1;
            end else if (take_action_ocimem_a) begin
                mon_a_d      = jdo_addr;
                jtag_clr_err = jdo[JDO_CLR_ERR_BIT];
                jtag_set_go  = jdo[JDO_SET_GO_BIT];
                if (jdo[JDO_RD_BIT]) begin
                    pend_valid_d = 1'b1;
                    pend_op_d    = JOP_RD;
                    pend_addr_d  = jdo_addr;
                end
            end else if (take_no_action_ocimem_a) begin
                pend_valid_d = 1'b1;
                pend_op_d    = JOP_RD;
                pend_addr_d  = mon_a_q;
            end else begin
                pend_valid_d = 1'b1;
                pend_op_d    = JOP_WR;
                pend_addr_d  = mon_a_q;
                pend_data_d  = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
            end
        end

        // ordering encodes precedence: JTAG set-go beats CPU clear, CPU error write beats JTAG clear
        if (st_wr) begin
            ready_d = writedata[STAT_READY_BIT];
            if (!writedata[STAT_GO_BIT]) go_d = 1'b0;
        end
        if (jtag_clr_err) error_d = 1'b0;
        if (st_wr)        error_d = writedata[STAT_ERROR_BIT];
        if (jtag_set_go)  go_d    = 1'b1;
        if (jtag_drop)    error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            go_q         <= 1'b0;
            cpu_ack_q    <= 1'b0;
            rd_status_q  <= 1'b0;
            status_rd_q  <= '0;
            pend_valid_q <= 1'b0;
            pend_op_q    <= JOP_RD;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            go_q         <= go_d;
            cpu_ack_q    <= cpu_ack_d;
            rd_status_q  <= rd_status_d;
            status_rd_q  <= status_rd_d;
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign readdata      = cpu_ack_q ? (rd_status_q ? status_rd_q : ram_q) : '0;
    assign waitrequest   = cpu_req & ~cpu_ack_q;
    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign monitor_go    = go_q;

endmodule

// File: tb/tb_cpu1_debug_monitor_mem.sv
// tb/tb_cpu1_debug_monitor_mem.sv - directed self-checking bench for cpu1_debug_monitor_mem
module tb_cpu1_debug_monitor_mem;
    import cpu1_debug_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [ADDR_W:0]   address;
    logic              read, write, debugaccess;
    logic [31:0]       writedata, readdata, MonDReg;
    logic [3:0]        byteenable;
    logic              waitrequest, monitor_ready, monitor_error, monitor_go;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rd;
    int          waits;

    cpu1_debug_monitor_mem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .debugaccess             (debugaccess),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd_bit, input logic clr, input logic go);
        logic [37:0] j;
        j        = '0;
        j[10:3]  = a;
        j[11]    = clr;
        j[12]    = rd_bit;
        j[13]    = go;
        return j;
    endfunction

    function automatic logic [37:0] jdo_d(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        step();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic cpu(input logic [ADDR_W:0] a, input logic w, input logic [31:0] wd,
                       input logic da, output logic [31:0] rdat, output int nwait);
        address     = a;
        write       = w;
        read        = ~w;
        writedata   = wd;
        debugaccess = da;
        byteenable  = 4'hF;
        nwait       = 0;
        rdat        = 'x;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (!waitrequest) break;
            nwait++;
            @(posedge clk);
            #2;
        end
        if (waitrequest) begin
            n_cmp++;
            n_err++;
            $error("FAIL cpu_timeout observed=waitrequest stuck expected=release");
        end
        rdat = readdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        address = '0;
        read = 1'b0;
        write = 1'b0;
        writedata = '0;
        byteenable = 4'hF;
        debugaccess = 1'b0;
        step();
        step();
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        chk("rst_wait", {31'b0, waitrequest}, 32'h0);
        reset_n = 1'b1;
        step();

        // 1: load address 0x10, write DEADBEEF
        jtag(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b0, 1'b0, 1'b0));
        jtag(1'b0, 1'b0, 1'b1, jdo_d(32'hDEADBEEF));
        step();
        step();
        chk("t1_mon_a", 32'(dut.mon_a_q), 32'h11);

        // 2: address 0x10 with read request, 3-cycle latency
        jtag(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0, 1'b0));
        step();
        step();
        chk("t2_mondreg_early", MonDReg, 32'h0);
        step();
        chk("t2_mondreg", MonDReg, 32'hDEADBEEF);
        chk("t2_mon_a", 32'(dut.mon_a_q), 32'h11);

        // 3: status write then JTAG error clear
        cpu(9'h100, 1'b1, 32'h3, 1'b1, rd, waits);
        chk("t3_wait_cycles", 32'(waits), 32'd1);
        chk("t3_ready", {31'b0, monitor_ready}, 32'h1);
        chk("t3_error", {31'b0, monitor_error}, 32'h1);
        jtag(1'b1, 1'b0, 1'b0, jdo_a(8'h00, 1'b0, 1'b1, 1'b0));
        chk("t3_error_clr", {31'b0, monitor_error}, 32'h0);
        chk("t3_ready_kept", {31'b0, monitor_ready}, 32'h1);
        cpu(9'h100, 1'b0, 32'h0, 1'b0, rd, waits);
        chk("t3_status_rd", rd, 32'h1);

        // 4: CPU and JTAG read in the same cycle, CPU first
        cpu(9'h005, 1'b1, 32'h12345678, 1'b1, rd, waits);
        jtag(1'b1, 1'b0, 1'b0, jdo_a(8'h05, 1'b0, 1'b0, 1'b0));
        address = 9'h005;
        read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        jdo = '0;
        #1;
        chk("t4_wait_first", {31'b0, waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        take_no_action_ocimem_a = 1'b0;
        #1;
        chk("t4_wait_second", {31'b0, waitrequest}, 32'h0);
        chk("t4_cpu_rd", readdata, 32'h12345678);
        @(posedge clk);
        #1;
        read = 1'b0;
        step();
        step();
        chk("t4_mondreg_hold", MonDReg, 32'hDEADBEEF);
        step();
        chk("t4_mondreg", MonDReg, 32'h12345678);
        chk("t4_mon_a", 32'(dut.mon_a_q), 32'h06);

        // 5: wrap and dropped strobe
        jtag(1'b1, 1'b0, 1'b0, jdo_a(8'hFF, 1'b0, 1'b0, 1'b0));
        jtag(1'b0, 1'b1, 1'b0, '0);
        step();
        step();
        step();
        chk("t5_wrap", 32'(dut.mon_a_q), 32'h00);
        chk("t5_error_pre", {31'b0, monitor_error}, 32'h0);
        jtag(1'b0, 1'b1, 1'b0, '0);
        jtag(1'b0, 1'b1, 1'b0, '0);
        chk("t5_error_drop", {31'b0, monitor_error}, 32'h1);
        step();
        step();
        chk("t5_mon_a_one", 32'(dut.mon_a_q), 32'h01);
        step();
        step();
        chk("t5_mon_a_no_second", 32'(dut.mon_a_q), 32'h01);

        // 6: reset in J_RD, then CPU write without debugaccess
        jtag(1'b0, 1'b1, 1'b0, '0);
        step();
        chk("t6_in_j_rd", 32'(dut.state_q), 32'(ST_J_RD));
        reset_n = 1'b0;
        #1;
        chk("t6_rst_mondreg", MonDReg, 32'h0);
        chk("t6_rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        step();
        chk("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset_n = 1'b1;
        step();
        step();
        step();
        step();
        chk("t6_pending_lost", 32'(dut.mon_a_q), 32'h00);
        chk("t6_mondreg_after", MonDReg, 32'h0);
        cpu(9'h010, 1'b1, 32'h0, 1'b0, rd, waits);
        chk("t6_nodbg_wait", 32'(waits), 32'd1);
        cpu(9'h010, 1'b0, 32'h0, 1'b0, rd, waits);
        chk("t6_ram_unchanged", rd, 32'hDEADBEEF);
        cpu(9'h100, 1'b1, 32'h3, 1'b0, rd, waits);
        chk("t6_status_nodbg", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
